// File: rtl/sqrt_shared_arbiter_pkg.sv
// Shared definitions for the round-robin front end of the shared square-root core.
package sqrt_shared_arbiter_pkg;

  localparam int SQRT_LATENCY_DEF = 3;
  localparam int MAX_REQ          = 8;

  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of cand at or after ptr, wrapping at n; returns ptr when cand is empty.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] cand,
                                         input logic [2:0]         ptr,
                                         input int                 n);
    logic [2:0] pick;
    logic [3:0] idx;
    pick = ptr;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = {1'b0, ptr} + 4'(k);
        if (idx >= 4'(n)) idx = idx - 4'(n);
        if (cand[idx[2:0]]) pick = idx[2:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sqrt_fixedPoint.sv
// Two-stage digit-by-digit fixed-point square root; the radical is left-padded to
// 2*outputWidth bits so the root keeps half the integer bits and the rest as fraction.
module sqrt_fixedPoint
  import sqrt_shared_arbiter_pkg::*;
#(
  parameter int inputWidth    = 24,
  parameter int inputDecWidth = 16,
  parameter int outputWidth   = 24
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic                   ena,
  input  logic [inputWidth-1:0]  radical,
  output logic [outputWidth-1:0] q,
  output logic [outputWidth:0]   remainder,
  output logic                   outData_valid
);
  localparam int RW      = 2 * outputWidth;
  localparam int OUT_DEC = outputWidth - (inputWidth - inputDecWidth + 1) / 2;
  localparam int SHIFT   = 2 * OUT_DEC - inputDecWidth;
  localparam int SPLIT   = outputWidth / 2;
  localparam int LW      = 2 * SPLIT;
  localparam int REMW    = outputWidth + 2;

  typedef struct packed {
    logic [REMW-1:0]        rem;
    logic [outputWidth-1:0] root;
  } acc_t;

  function automatic acc_t sqrt_digit(input acc_t a, input logic [1:0] pair);
    acc_t            r;
    logic [REMW-1:0] trial;
    r.rem  = {a.rem[REMW-3:0], pair};
    trial  = {a.root, 2'b01};
    r.root = {a.root[outputWidth-2:0], 1'b0};
    if (r.rem >= trial) begin
      r.rem  = r.rem - trial;
      r.root = {a.root[outputWidth-2:0], 1'b1};
    end
    return r;
  endfunction

  acc_t                   acc_p1_d, acc_p1_q;
  logic [LW-1:0]          low_p1_d, low_p1_q;
  logic [outputWidth-1:0] root_p2_d, root_p2_q;
  logic [outputWidth:0]   rem_p2_d, rem_p2_q;
  logic                   vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q;

  // p1: upper root digits
  always_comb begin
    logic [RW-1:0] rad;
    acc_t          a;
    rad = RW'(radical) << SHIFT;
    a   = '0;
    for (int i = outputWidth - 1; i >= SPLIT; i--) a = sqrt_digit(a, rad[2*i +: 2]);
    acc_p1_d = a;
    low_p1_d = rad[LW-1:0];
    vld_p1_d = ena;
  end

  // p2: remaining digits from the carried low radicand bits
  always_comb begin
    acc_t a;
    a = acc_p1_q;
    for (int i = SPLIT - 1; i >= 0; i--) a = sqrt_digit(a, low_p1_q[2*i +: 2]);
    root_p2_d = a.root;
    rem_p2_d  = a.rem[outputWidth:0];
    vld_p2_d  = vld_p1_q;
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ena) begin
      acc_p1_q  <= acc_p1_d;
      low_p1_q  <= low_p1_d;
      root_p2_q <= root_p2_d;
      rem_p2_q  <= rem_p2_d;
    end
  end

  assign q             = root_p2_q;
  assign remainder     = rem_p2_q;
  assign outData_valid = vld_p2_q;

endmodule

// File: rtl/sqrt_shared_arbiter.sv
// Round-robin front end sharing one pipelined sqrt core among NUM_REQ requesters;
// a tag pipe running alongside the core routes each result back to its owner.
module sqrt_shared_arbiter
  import sqrt_shared_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int inputWidth    = 24,
  parameter int inputDecWidth = 16,
  parameter int outputWidth   = 24,
  parameter int SQRT_LATENCY  = SQRT_LATENCY_DEF
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_REQ-1:0]                  req_enable,
  input  logic [NUM_REQ-1:0]                  in_valid,
  input  logic [NUM_REQ*inputWidth-1:0]       in_data,
  output logic [NUM_REQ-1:0]                  in_ready,
  output logic [NUM_REQ-1:0]                  out_valid,
  output logic [outputWidth-1:0]              out_q,
  output logic [outputWidth:0]                out_remainder,
  output logic [$clog2(NUM_REQ)-1:0]          out_tag,
  output logic [$clog2(SQRT_LATENCY+1)-1:0]   in_flight
);
  localparam int TW  = tag_width(NUM_REQ);
  localparam int IFW = $clog2(SQRT_LATENCY + 1);

  logic [MAX_REQ-1:0]      cand;
  logic [TW-1:0]           grant_idx;
  logic                    accept, result_vld;
  logic [TW-1:0]           rr_d, rr_q;
  logic [inputWidth-1:0]   launch_d, launch_q;
  logic [SQRT_LATENCY-1:0] tag_vld_d, tag_vld_q;
  logic [TW-1:0]           tag_idx_d [SQRT_LATENCY];
  logic [TW-1:0]           tag_idx_q [SQRT_LATENCY];
  logic [IFW-1:0]          in_flight_d, in_flight_q;
  logic                    core_vld_unused;

  // Grant is suppressed during reset so nothing is accepted into a pipe being flushed.
  always_comb begin
    cand                = '0;
    cand[NUM_REQ-1:0]   = in_valid & req_enable;
    grant_idx           = TW'(rr_pick(cand, 3'(rr_q), NUM_REQ));
    accept              = reset_n && (cand != '0);
    in_ready            = '0;
    if (accept) in_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    rr_d     = rr_q;
    launch_d = launch_q;
    if (accept) begin
      rr_d     = (grant_idx == TW'(NUM_REQ - 1)) ? '0 : grant_idx + TW'(1);
      launch_d = in_data[grant_idx*inputWidth +: inputWidth];
    end
    tag_vld_d    = {tag_vld_q[SQRT_LATENCY-2:0], accept};
    tag_idx_d[0] = grant_idx;
    for (int s = 1; s < SQRT_LATENCY; s++) tag_idx_d[s] = tag_idx_q[s-1];
    result_vld  = tag_vld_q[SQRT_LATENCY-1];
    in_flight_d = in_flight_q + IFW'(accept) - IFW'(result_vld);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_q        <= '0;
      tag_vld_q   <= '0;
      in_flight_q <= '0;
      for (int s = 0; s < SQRT_LATENCY; s++) tag_idx_q[s] <= '0;
    end else begin
      rr_q        <= rr_d;
      tag_vld_q   <= tag_vld_d;
      in_flight_q <= in_flight_d;
      for (int s = 0; s < SQRT_LATENCY; s++) tag_idx_q[s] <= tag_idx_d[s];
    end
  end

  // p0: launch register feeding the core
  always_ff @(posedge clk) begin
    launch_q <= launch_d;
  end

  sqrt_fixedPoint #(
    .inputWidth   (inputWidth),
    .inputDecWidth(inputDecWidth),
    .outputWidth  (outputWidth)
  ) u_sqrt (
    .clk          (clk),
    .aclr         (~reset_n),
    .ena          (1'b1),
    .radical      (launch_q),
    .q            (out_q),
    .remainder    (out_remainder),
    .outData_valid(core_vld_unused)
  );

  // Only the tag pipe qualifies results; core warm-up output is never presented.
  always_comb begin
    out_valid = '0;
    out_tag   = '0;
    if (result_vld) begin
      out_valid[tag_idx_q[SQRT_LATENCY-1]] = 1'b1;
      out_tag                              = tag_idx_q[SQRT_LATENCY-1];
    end
  end

  assign in_flight = in_flight_q;

endmodule

// File: tb/tb_sqrt_shared_arbiter.sv
// Directed-plus-random bench for sqrt_shared_arbiter against a queue-based reference model.
module tb_sqrt_shared_arbiter;
  localparam int N       = 4;
  localparam int IW      = 24;
  localparam int OW      = 24;
  localparam int LAT     = 3;
  localparam int Q_SHIFT = 24;  // root carries 20 fractional bits: sqrt(X/2^16)*2^20

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req_enable, in_valid, in_ready, out_valid;
  logic [N*IW-1:0]   in_data;
  logic [OW-1:0]     out_q;
  logic [OW:0]       out_remainder;
  logic [1:0]        out_tag;
  logic [1:0]        in_flight;

  always #5 clk = ~clk;

  sqrt_shared_arbiter #(
    .NUM_REQ(N), .inputWidth(IW), .inputDecWidth(16), .outputWidth(OW), .SQRT_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_enable(req_enable), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_q(out_q),
    .out_remainder(out_remainder), .out_tag(out_tag), .in_flight(in_flight)
  );

  typedef struct { int due; int tag; longint q; longint rem; } res_t;
  res_t        exp_q[$];
  int          rr = 0, cyc = 0, n_cmp = 0, n_fail = 0;
  logic [OW-1:0] last_q;
  logic [OW:0]   last_rem;
  int          last_tag = -1;

  function automatic longint isqrt(input longint x);
    longint r, t;
    r = 0;
    for (int b = 25; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  function automatic logic [N*IW-1:0] pack4(input logic [IW-1:0] a, input logic [IW-1:0] b,
                                            input logic [IW-1:0] c, input logic [IW-1:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [N*IW-1:0] rand_data();
    return pack4(IW'($urandom), IW'($urandom), IW'($urandom), IW'($urandom));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: apply inputs, check mid-cycle against the model, then advance the model.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] en, input logic rn,
                      input logic [N*IW-1:0] d);
    int            g;
    res_t          r;
    logic [IW-1:0] radv;
    longint        x;
    in_valid = v; req_enable = en; reset_n = rn; in_data = d;
    #4;
    g = -1;
    if (rn) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && v[(rr + k) % N] && en[(rr + k) % N]) g = (rr + k) % N;
      end
    end
    chk("in_ready", 64'(in_ready), (g >= 0) ? (64'(1) << g) : 64'(0));
    chk("in_flight", 64'(in_flight), 64'(exp_q.size()));
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      chk("out_valid", 64'(out_valid), 64'(1) << r.tag);
      chk("out_tag", 64'(out_tag), 64'(r.tag));
      chk("out_q", 64'(out_q), 64'(r.q));
      chk("out_rem", 64'(out_remainder), 64'(r.rem));
      last_q = out_q; last_rem = out_remainder; last_tag = r.tag;
    end else begin
      chk("out_valid_idle", 64'(out_valid), 64'(0));
      chk("out_tag_idle", 64'(out_tag), 64'(0));
    end
    @(posedge clk); #1;
    if (!rn) begin
      exp_q.delete();
      rr = 0;
    end else if (g >= 0) begin
      radv  = d[g*IW +: IW];
      x     = longint'(radv) << Q_SHIFT;
      r.due = cyc + LAT;
      r.tag = g;
      r.q   = isqrt(x);
      r.rem = x - r.q * r.q;
      exp_q.push_back(r);
      rr = (g + 1) % N;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'h0, 4'hF, 1'b1, '0);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = '0; req_enable = '0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;

    // reset state, then core warm-up with no requests
    step(4'h0, 4'hF, 1'b0, '0);
    idle(5);

    // single request on requester 2, radical 4.0
    step(4'b0100, 4'hF, 1'b1, pack4(24'h0, 24'h0, 24'h040000, 24'h0));
    idle(4);
    chk("t1_q", 64'(last_q), 64'h200000);
    chk("t1_rem", 64'(last_rem), 64'h0);
    chk("t1_tag", 64'(last_tag), 64'd2);

    // all four valid from rr=0
    step(4'h0, 4'hF, 1'b0, '0);
    repeat (8) step(4'hF, 4'hF, 1'b1, rand_data());
    idle(4);

    // requester 2 disabled
    repeat (6) step(4'hF, 4'b1011, 1'b1, rand_data());
    idle(4);

    // reset while samples are in the pipe
    step(4'hF, 4'hF, 1'b1, rand_data());
    step(4'hF, 4'hF, 1'b1, rand_data());
    step(4'hF, 4'hF, 1'b0, rand_data());
    idle(5);

    // zero and full-scale radicals
    step(4'b0011, 4'hF, 1'b1, pack4(24'h0, 24'hFFFFFF, 24'h0, 24'h0));
    step(4'b0010, 4'hF, 1'b1, pack4(24'h0, 24'hFFFFFF, 24'h0, 24'h0));
    idle(4);
    chk("t6_q", 64'(last_q), 64'hFFFFFF);
    chk("t6_rem", 64'(last_rem), 64'hFFFFFF);
    chk("t6_tag", 64'(last_tag), 64'd1);

    // enable cleared while requester 3 is mid-pipe
    step(4'b1000, 4'b1000, 1'b1, rand_data());
    repeat (4) step(4'h0, 4'b0111, 1'b1, '0);

    // random traffic with occasional reset
    repeat (120) step(4'($urandom), 4'($urandom), ($urandom_range(0, 39) != 0), rand_data());
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
